// File: rtl/mlp_conv_pkg.sv
// Shared types and constants for the mlp_conv pipeline (weight_store -> conv_window_mac).
// Holds element/dimension constants, the MAC state enum and the R/S clamp helper.
package mlp_conv_pkg;

   localparam int ELEM_WIDTH    = 8;
   localparam int MAX_DIM       = 5;
   localparam int ROW_SUM_WIDTH = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } mac_state_t;

   // Zero-sized filters behave as 1; anything beyond the hardware maximum saturates.
   function automatic logic [3:0] clamp_dim(input logic [3:0] dim);
      if (dim == 4'd0) return 4'd1;
      if (dim > 4'(MAX_DIM)) return 4'(MAX_DIM);
      return dim;
   endfunction

endpackage

// File: rtl/row_dot5.sv
// Combinational signed dot product of two packed rows, elements k >= dim_s masked to zero.
// Element k of each row sits at bits [BUFFER_WIDTH-1-ELEM_WIDTH*k -: ELEM_WIDTH].
module row_dot5
   import mlp_conv_pkg::*;
#(
   parameter int BUFFER_WIDTH = 40
) (
   input  logic [BUFFER_WIDTH-1:0]         row_a,
   input  logic [BUFFER_WIDTH-1:0]         row_b,
   input  logic [3:0]                      dim_s,
   output logic signed [ROW_SUM_WIDTH-1:0] row_sum
);

   logic signed [2*ELEM_WIDTH-1:0] prod [MAX_DIM];

   // NOTE: every variable written in always_comb gets a value before any branch, so no latch is inferred.
   always_comb begin
      row_sum = '0;
      for (int k = 0; k < MAX_DIM; k++) begin
         prod[k] = '0;
         if (k < int'(dim_s)) begin
            prod[k] = $signed(row_a[BUFFER_WIDTH-1-ELEM_WIDTH*k -: ELEM_WIDTH]) *
                      $signed(row_b[BUFFER_WIDTH-1-ELEM_WIDTH*k -: ELEM_WIDTH]);
         end
         row_sum = row_sum + ROW_SUM_WIDTH'(prod[k]);
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// Latches R filter rows from weight_store and emits one signed R x S window sum per window.
// Optional feature: define CONV_BIAS_EN to add a BIAS input that seeds every window's accumulator.
module conv_window_mac
   import mlp_conv_pkg::*;
#(
   parameter int BUFFER_WIDTH = 40,
   parameter int ACC_WIDTH    = 32
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic [3:0]              PARAM_R,
   input  logic [3:0]              PARAM_S,
   input  logic                    W_FULL,
   input  logic [BUFFER_WIDTH-1:0] W_DATA_0,
   input  logic [BUFFER_WIDTH-1:0] W_DATA_1,
   input  logic [BUFFER_WIDTH-1:0] W_DATA_2,
   input  logic [BUFFER_WIDTH-1:0] W_DATA_3,
   input  logic [BUFFER_WIDTH-1:0] W_DATA_4,
`ifdef CONV_BIAS_EN
   input  logic [ACC_WIDTH-1:0]    BIAS,
`endif
   output logic                    W_DONE,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic [BUFFER_WIDTH-1:0] IN_DATA,
   input  logic                    IN_LAST,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic [ACC_WIDTH-1:0]    OUT_DATA,
   output logic                    OUT_LAST
);

   mac_state_t                      state_q, state_d;
   logic [BUFFER_WIDTH-1:0]         w_rows [MAX_DIM];
   logic [3:0]                      r_dim, s_dim;
   logic [2:0]                      r_cnt;
   logic [ACC_WIDTH-1:0]            acc;
   logic [ACC_WIDTH-1:0]            acc_start, load_start, row_ext;
   logic signed [ROW_SUM_WIDTH-1:0] row_sum;
   logic                            load_w, retire, in_hs, out_hs, final_row;

   assign in_hs     = IN_VALID && IN_READY;
   assign out_hs    = OUT_VALID && OUT_READY;
   assign final_row = ({1'b0, r_cnt} == (r_dim - 4'd1));
   assign row_ext   = ACC_WIDTH'(row_sum);

   row_dot5 #(.BUFFER_WIDTH(BUFFER_WIDTH)) u_row_dot5 (
      .row_a   (w_rows[r_cnt]),
      .row_b   (IN_DATA),
      .dim_s   (s_dim),
      .row_sum (row_sum)
   );

`ifdef CONV_BIAS_EN
   logic [ACC_WIDTH-1:0] bias_q;

   assign acc_start  = bias_q;
   assign load_start = BIAS;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) bias_q <= '0;
      else if (load_w) bias_q <= BIAS;
   end
`else
   assign acc_start  = '0;
   assign load_start = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      IN_READY = 1'b0;
      load_w   = 1'b0;
      retire   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (W_FULL) begin
               load_w  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // Single-entry output register: only stall while a result sits unaccepted.
            IN_READY = !OUT_VALID || OUT_READY;
            if (IN_VALID && IN_READY && final_row && IN_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            if (out_hs) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         // NOTE: the five weight rows are few and must read as cleared after reset, so they are reset explicitly.
         for (int k = 0; k < MAX_DIM; k++) w_rows[k] <= '0;
         r_dim     <= '0;
         s_dim     <= '0;
         r_cnt     <= '0;
         acc       <= '0;
         W_DONE    <= 1'b0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_LAST  <= 1'b0;
      end else begin
         W_DONE <= retire;
         if (load_w) begin
            w_rows[0] <= W_DATA_0;
            w_rows[1] <= W_DATA_1;
            w_rows[2] <= W_DATA_2;
            w_rows[3] <= W_DATA_3;
            w_rows[4] <= W_DATA_4;
            r_dim     <= clamp_dim(PARAM_R);
            s_dim     <= clamp_dim(PARAM_S);
            acc       <= load_start;
         end else if (retire) begin
            for (int k = 0; k < MAX_DIM; k++) w_rows[k] <= '0;
         end

         if (out_hs) OUT_VALID <= 1'b0;

         // A final-row handshake in the same cycle as an output handshake overwrites the old result.
         if (in_hs) begin
            if (final_row) begin
               OUT_DATA  <= acc + row_ext;
               OUT_VALID <= 1'b1;
               OUT_LAST  <= IN_LAST;
               acc       <= acc_start;
               r_cnt     <= '0;
            end else begin
               acc   <= acc + row_ext;
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: directed windows plus randomized weight sets,
// checked against a window-sum model and a queue of expected results.
module tb_conv_window_mac;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic [3:0]  PARAM_R = '0, PARAM_S = '0;
   logic        W_FULL = 1'b0;
   logic [39:0] W_DATA_0 = '0, W_DATA_1 = '0, W_DATA_2 = '0, W_DATA_3 = '0, W_DATA_4 = '0;
   logic        W_DONE;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [39:0] IN_DATA = '0;
   logic        IN_LAST = 1'b0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] OUT_DATA;
   logic        OUT_LAST;
`ifdef CONV_BIAS_EN
   logic [31:0] BIAS = '0;
`endif

   conv_window_mac dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .PARAM_R   (PARAM_R),
      .PARAM_S   (PARAM_S),
      .W_FULL    (W_FULL),
      .W_DATA_0  (W_DATA_0),
      .W_DATA_1  (W_DATA_1),
      .W_DATA_2  (W_DATA_2),
      .W_DATA_3  (W_DATA_3),
      .W_DATA_4  (W_DATA_4),
`ifdef CONV_BIAS_EN
      .BIAS      (BIAS),
`endif
      .W_DONE    (W_DONE),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .IN_LAST   (IN_LAST),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_LAST  (OUT_LAST)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t expq [$];
   bit   exp_done = 1'b0;
   int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
   bit   gap_mode = 1'b0;
   int   stall_total = 0;

   int bw [5][5];          // weights presented on the bus
   int xw [5][5];          // activation rows of the current window
   int mw [5][5];          // weights the model believes are latched
   int mr, ms, mbias;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   function automatic int clampi(input int v);
      if (v == 0) return 1;
      if (v > 5) return 5;
      return v;
   endfunction

   function automatic logic [39:0] pack_w(input int r);
      logic [39:0] v;
      v = '0;
      for (int k = 0; k < 5; k++) v[39-8*k -: 8] = bw[r][k][7:0];
      return v;
   endfunction

   function automatic logic [39:0] pack_x(input int r);
      logic [39:0] v;
      v = '0;
      for (int k = 0; k < 5; k++) v[39-8*k -: 8] = xw[r][k][7:0];
      return v;
   endfunction

   function automatic int rand_elem();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // Output checker: the front of the queue must be on OUT_DATA whenever OUT_VALID is high.
   always @(negedge CLK) begin
      if (!RESETN) begin
         expq.delete();
         exp_done = 1'b0;
      end else begin
         check("w_done", {31'd0, W_DONE}, {31'd0, exp_done});
         exp_done = 1'b0;
         if (OUT_VALID) begin
            if (expq.size() == 0) begin
               check("spurious_out_valid", {31'd0, OUT_VALID}, 32'd0);
            end else begin
               check("out_data", OUT_DATA, expq[0].data);
               check("out_last", {31'd0, OUT_LAST}, {31'd0, expq[0].last});
               if (OUT_READY) begin
                  exp_done = expq[0].last;
                  void'(expq.pop_front());
               end
            end
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      case (ready_mode)
         0:       OUT_READY = 1'b0;
         1:       OUT_READY = 1'b1;
         default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic load_weights(input int r_val, input int s_val, input int bias_val);
      PARAM_R  = 4'(r_val);
      PARAM_S  = 4'(s_val);
      W_DATA_0 = pack_w(0);
      W_DATA_1 = pack_w(1);
      W_DATA_2 = pack_w(2);
      W_DATA_3 = pack_w(3);
      W_DATA_4 = pack_w(4);
`ifdef CONV_BIAS_EN
      BIAS  = 32'(bias_val);
      mbias = bias_val;
`else
      mbias = 0;
      if (bias_val != 0) mbias = 0;
`endif
      W_FULL = 1'b1;
      @(posedge CLK);
      #1;
      W_FULL = 1'b0;
      mr = clampi(r_val);
      ms = clampi(s_val);
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) mw[r][k] = bw[r][k];
      check("in_ready_after_load", {31'd0, IN_READY}, 32'd1);
      // The latched set must not follow the bus once running.
      W_DATA_0 = {$urandom, 8'h00};
      W_DATA_1 = {$urandom, 8'h11};
      W_DATA_2 = {$urandom, 8'h22};
      W_DATA_3 = {$urandom, 8'h33};
      W_DATA_4 = {$urandom, 8'h44};
      PARAM_R  = 4'($urandom_range(0, 15));
      PARAM_S  = 4'($urandom_range(0, 15));
`ifdef CONV_BIAS_EN
      BIAS = $urandom;
`endif
   endtask

   task automatic send_row(input int r, input bit last);
      int  stall;
      bit  ok;
      stall = 0;
      ok    = 1'b0;
      IN_DATA  = pack_x(r);
      IN_LAST  = last;
      IN_VALID = 1'b1;
      while (!ok && stall <= 200) begin
         @(negedge CLK);
         if (IN_READY) ok = 1'b1;
         else stall++;
      end
      stall_total += stall;
      check("in_ready_timeout", {31'd0, ok}, 32'd1);
      if (ok) @(posedge CLK);
      #1;
   endtask

   task automatic send_window(input bit last, input bit rand_x);
      int sum;
      if (rand_x)
         for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++) xw[r][k] = rand_elem();
      sum = mbias;
      for (int r = 0; r < mr; r++)
         for (int k = 0; k < ms; k++) sum += mw[r][k] * xw[r][k];
      for (int r = 0; r < mr; r++) begin
         if (gap_mode && $urandom_range(0, 3) == 0) begin
            IN_VALID = 1'b0;
            @(posedge CLK);
            #1;
         end
         send_row(r, (r == mr - 1) ? last : 1'($urandom_range(0, 1)));
      end
      expq.push_back('{data: sum, last: last});
      IN_VALID = 1'b0;
      check("out_valid_latency", {31'd0, OUT_VALID}, 32'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!W_DONE && n < 300);
      check("w_done_seen", {31'd0, W_DONE}, 32'd1);
   endtask

   task automatic fill_bw(input int v);
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) bw[r][k] = v;
   endtask

   task automatic rand_bw();
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) bw[r][k] = rand_elem();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      mbias = 0;
      mr = 1;
      ms = 1;
      #12;
      check("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("reset_in_ready",  {31'd0, IN_READY},  32'd0);
      check("reset_w_done",    {31'd0, W_DONE},    32'd0);
      check("reset_out_data",  OUT_DATA,           32'd0);
      check("reset_out_last",  {31'd0, OUT_LAST},  32'd0);
      @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      check("idle_in_ready", {31'd0, IN_READY}, 32'd0);

      // 1x1 single window
      ready_mode = 1;
      rand_bw();
      bw[0][0] = 3;
      load_weights(1, 1, 0);
      xw[0][0] = 5;
      for (int k = 1; k < 5; k++) xw[0][k] = 127;
      send_window(1'b1, 1'b0);
      check("t1_out_data", OUT_DATA, 32'd15);
      check("t1_out_last", {31'd0, OUT_LAST}, 32'd1);
      wait_done();

      // 3x3 masking
      fill_bw(-1);
      load_weights(3, 3, 0);
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) xw[r][k] = (k < 3) ? 2 : 127;
      send_window(1'b1, 1'b0);
      check("t2_out_data", OUT_DATA, 32'hFFFF_FFEE);
      wait_done();

      // 5x5 extremes, three back-to-back windows
      fill_bw(127);
      load_weights(5, 5, 0);
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) xw[r][k] = -128;
      stall_total = 0;
      for (int w = 0; w < 3; w++) begin
         send_window(w == 2, 1'b0);
         check("t3_out_data", OUT_DATA, 32'(-406400));
      end
      check("t3_no_bubble", 32'(stall_total), 32'd0);
      wait_done();

      // Backpressure 2x2
      rand_bw();
      load_weights(2, 2, 0);
      ready_mode = 0;
      send_window(1'b0, 1'b1);
      repeat (3) begin
         @(negedge CLK);
         check("t4_in_ready_stall", {31'd0, IN_READY}, 32'd0);
         check("t4_out_hold_valid", {31'd0, OUT_VALID}, 32'd1);
      end
      ready_mode = 1;
      send_window(1'b1, 1'b1);
      wait_done();

      // Retire and reload
      rand_bw();
      load_weights(2, 2, 0);
      send_window(1'b0, 1'b1);
      send_window(1'b1, 1'b1);
      wait_done();
      repeat (3) begin
         @(negedge CLK);
         check("t5_idle_in_ready", {31'd0, IN_READY}, 32'd0);
      end
      rand_bw();
      load_weights(2, 2, 0);
      send_window(1'b1, 1'b1);
      wait_done();

      // Reset mid-window
      rand_bw();
      load_weights(5, 5, 0);
      send_window(1'b0, 1'b1);
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++) xw[r][k] = rand_elem();
      send_row(0, 1'b0);
      send_row(1, 1'b0);
      IN_VALID = 1'b0;
      #1;
      RESETN = 1'b0;
      #1;
      check("t6_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("t6_rst_in_ready",  {31'd0, IN_READY},  32'd0);
      check("t6_rst_out_data",  OUT_DATA,           32'd0);
      check("t6_rst_out_last",  {31'd0, OUT_LAST},  32'd0);
      check("t6_rst_w_done",    {31'd0, W_DONE},    32'd0);
      @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      rand_bw();
      load_weights(5, 5, 0);
      send_window(1'b1, 1'b1);
      wait_done();

      // Randomized weight sets, dimensions (including clamped ones), gaps and backpressure
      ready_mode = 2;
      gap_mode   = 1'b1;
      for (int set = 0; set < 15; set++) begin
         int nwin;
         rand_bw();
         load_weights(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom));
         nwin = int'($urandom_range(1, 3));
         for (int w = 0; w < nwin; w++) send_window(w == nwin - 1, 1'b1);
         wait_done();
      end

      repeat (3) @(negedge CLK);
      check("final_queue_empty", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Downstream consumer of `weight_store` in the `mlp_conv` pipeline. Once the weight store reports FULL, this block latches its R filter rows and computes one signed int8 dot product per R×S activation window. Activations stream in one row per beat over a valid/ready handshake. Each completed window is emitted as a 32-bit accumulator. The block signals when a weight set is retired so the weight store can be reloaded.

## Interface
- `BUFFER_WIDTH`, 40, packed row width; must match `weight_store`.
- `ELEM_WIDTH`, 8, signed element width.
- `MAX_DIM`, 5, maximum R and S.
- `ACC_WIDTH`, 32, accumulator/output width.

Ports (clock and reset first):
- `CLK`  in  1  single clock; all logic is rising-edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `PARAM_R`  in  4  filter height; sampled at weight latch.
- `PARAM_S`  in  4  filter width; sampled at weight latch.
- `W_FULL`  in  1  `FULL` from `weight_store`.
- `W_DATA_0` … `W_DATA_4`  in  BUFFER_WIDTH each  weight rows 0–4; element k sits at bits [39-8k -: 8].
- `W_DONE`  out  1  one-cycle pulse when the weight set is retired.
- `IN_VALID`  in  1  activation row valid.
- `IN_READY`  out  1  activation row accepted when high together with `IN_VALID`.
- `IN_DATA`  in  BUFFER_WIDTH  one window row, packed the same way as the weights.
- `IN_LAST`  in  1  marks the final window of the current weight set; meaningful only on a window's final row.
- `OUT_VALID`  out  1  result valid.
- `OUT_READY`  in  1  downstream accepts the result.
- `OUT_DATA`  out  ACC_WIDTH  signed window sum.
- `OUT_LAST`  out  1  result belongs to the window flagged by `IN_LAST`.

## Operation
State machine states: IDLE, RUN, DRAIN.

- **IDLE**
  - `IN_READY`=0.
  - On an edge with `W_FULL`=1: latch all five weight rows, `PARAM_R` and `PARAM_S`, then go to RUN.
  - R/S values of 0 are treated as 1; values above 5 are clamped to 5.
- **RUN**
  - Row counter `r` (0..R-1) advances on each input handshake.
  - Per accepted row: `acc += sum over k<S of W_r[k]*IN_DATA[k]`, all operands signed.
  - Elements with k≥S are masked to zero in both operands. Rows r≥R are never used.
  - Products are 16 bits, the row sum is 19 bits, both sign-extended. `acc` wraps in two's complement at ACC_WIDTH.
  - On the handshake of row R-1:
    - load `acc` plus the current row sum into the output register; set `OUT_VALID`=1 and `OUT_LAST`=`IN_LAST`;
    - clear `acc` and reset `r`=0;
    - if `IN_LAST`=1, go to DRAIN.
- **DRAIN**
  - `IN_READY`=0.
  - On the output handshake: pulse `W_DONE` for exactly one cycle, go to IDLE, clear the latched weights.
- **IN_READY in RUN**: `!OUT_VALID || OUT_READY`. The output register is single-entry, so input stalls only while a result is unaccepted.
- **Weight bus changes**: ignored outside IDLE. `W_FULL` staying high after `W_DONE` starts a new load on the next IDLE cycle.

## Timing
- **Reset values**: all outputs 0, state IDLE, `acc`=0, `r`=0.
- **Reset mid-operation**: clears everything immediately; partial sums are lost.
- **Weight load**: `W_FULL` high at edge N → RUN and `IN_READY`=1 from edge N.
- **Result latency**: `OUT_VALID` rises one cycle after the final-row handshake.
- **Throughput**: one row per cycle with `OUT_READY` held high. Back-to-back windows run with no bubble.
- **Output stability**: `OUT_DATA` and `OUT_LAST` hold stable while `OUT_VALID && !OUT_READY`.
- **Simultaneous output handshake and final-row input handshake**: the new result replaces the old one in the same cycle.
- **W_DONE**: asserted in the cycle after the `OUT_LAST` handshake.

## Configuration
- **`CONV_BIAS_EN` defined**:
  - adds input `BIAS` [ACC_WIDTH-1:0], latched alongside the weights;
  - `acc` starts at `BIAS` for every window;
  - `OUT_DATA` includes the bias.
- **`CONV_BIAS_EN` undefined**: no `BIAS` port; `acc` starts at 0.

## Structure
- **Package `mlp_conv_pkg`**: `ELEM_WIDTH`, `MAX_DIM`, the state enum `mac_state_t`, and the function `clamp_dim()` (0→1, >5→5).
- **Sub-module `row_dot5`**:
  - purely combinational;
  - inputs: two packed rows and S;
  - output: the masked signed 19-bit sum.
- **Top level**: FSM, row counter, accumulator, weight registers, output register.

## Test plan
1. **1×1, single window**: weight byte0=0x03, `IN_DATA` byte0=0x05 (other bytes 0x7F), `IN_LAST`=1 → `OUT_DATA`=15 one cycle after the handshake, `OUT_LAST`=1, `W_DONE` pulses after the output handshake.
2. **3×3 masking**: all weights 0xFF, rows have bytes0–2=0x02 and bytes3–4=0x7F → `OUT_DATA`=-18 (0xFFFFFFEE).
3. **5×5 extremes**: weights 0x7F, inputs 0x80 → `OUT_DATA`=-406400; three back-to-back windows with `OUT_READY`=1 → results on consecutive 5-cycle boundaries with no bubble.
4. **Backpressure (2×2)**: `OUT_READY`=0 after the first result → `IN_READY` drops and the first `OUT_DATA` holds; raise `OUT_READY` → second window is accepted and both results appear in order.
5. **Retire and reload**: two 2×2 windows, `IN_LAST` on the second → `OUT_LAST` only on the second, `W_DONE` one pulse, `IN_READY`=0 until `W_FULL` is reasserted with new weights, then the next result uses the new weights.
6. **Reset mid-window**: assert `RESETN`=0 after 2 of 5 rows → all outputs 0 at once; after reload, a fresh 5×5 window yields the correct sum with no residue.
